// File: rtl/safe_pkg.sv
// Shared definitions for the safe and its automated cracker.
// Holds the default switch width, the derived hint width, the cracker state
// encoding and the seven-segment patterns shown for the OPEN/LOCKED status.
package safe_pkg;

    localparam int unsigned N_SW   = 10;
    localparam int unsigned HINT_W = $clog2(N_SW + 1);

    // Cracker state encoding, kept as plain constants for legacy tools
    typedef logic [2:0] crack_state_t;
    localparam crack_state_t ST_IDLE   = 3'd0;
    localparam crack_state_t ST_BASE   = 3'd1;
    localparam crack_state_t ST_PROBE  = 3'd2;
    localparam crack_state_t ST_SUBMIT = 3'd3;
    localparam crack_state_t ST_RESULT = 3'd4;
    localparam crack_state_t ST_DONE   = 3'd5;

    // Active-low seven-segment glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_OPEN   = 7'b1000000; // "O"
    localparam logic [6:0] HEX_LOCKED = 7'b1000111; // "L"

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter used for both the hint-settle and the result windows.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   load      - (re)start the count with load_val
//   load_val  - expired fires load_val+1 cycles after the loading edge
//   expired   - one-cycle pulse when the count has run out
module settle_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic         active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            cnt_q    <= load_val;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign expired = active_q && (cnt_q == '0);

endmodule

// File: rtl/safe_cracker.sv
// Automated initiator for the combination safe. Takes a baseline mismatch
// count with all switches off, then flips one switch at a time: a drop in the
// hint means that password bit is 1. Submits the recovered code and reports.
// Ports:
//   CLK50, reset   - clock, async active-high reset (release synchronised)
//   start          - launch request, sampled only while idle
//   locked, hint   - safe lock status and mismatch count
//   sw_out, enter  - registered switch drive and one-cycle enter strobe
//   busy, done     - run in progress / result valid
//   found, pw_out  - safe unlocked flag and recovered password, valid with done
module safe_cracker
    import safe_pkg::*;
#(
    parameter int unsigned N_SW          = safe_pkg::N_SW,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned RESULT_CYCLES = 16,
    localparam int unsigned HW           = $clog2(N_SW + 1)
) (
    input  logic            CLK50,
    input  logic            reset,
    input  logic            start,
    input  logic            locked,
    input  logic [HW-1:0]   hint,
    output logic [N_SW-1:0] sw_out,
    output logic            enter,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic [N_SW-1:0] pw_out
);

    localparam int unsigned IW   = (N_SW > 1) ? $clog2(N_SW) : 1;
    localparam int unsigned TMAX = (SETTLE_CYCLES > RESULT_CYCLES) ? SETTLE_CYCLES : RESULT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    // Async assert, release aligned to CLK50
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    crack_state_t    state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N_SW-1:0] guess_q, guess_d;
    logic [HW-1:0]   h0_q, h0_d;
    logic [N_SW-1:0] sw_q, sw_d;
    logic            enter_q, enter_d;
    logic            found_q, found_d;
    logic [N_SW-1:0] pw_q, pw_d;
    logic            err_q, err_d;

    logic            t_load, t_exp;
    logic [TW-1:0]   t_val;

    // One extra bit so h0-1 at h0=0 cannot alias a legal hint
    logic [HW:0]     hint_ext, h0_ext;
    assign hint_ext = {1'b0, hint};
    assign h0_ext   = {1'b0, h0_q};

    settle_timer #(.W(TW)) u_timer (
        .clk      (CLK50),
        .rst      (rst_int),
        .load     (t_load),
        .load_val (t_val),
        .expired  (t_exp)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        guess_d = guess_q;
        h0_d    = h0_q;
        sw_d    = sw_q;
        enter_d = 1'b0;
        found_d = found_q;
        pw_d    = pw_q;
        err_d   = err_q;
        t_load  = 1'b0;
        t_val   = TW'(SETTLE_CYCLES - 1);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BASE;
                    sw_d    = '0;
                    guess_d = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    found_d = 1'b0;
                    pw_d    = '0;
                    t_load  = 1'b1;
                end
            end
            ST_BASE, ST_PROBE, ST_SUBMIT: begin
                if (t_exp) begin
                    if (!locked) begin
                        // Hint is meaningless once unlocked: abandon the run
                        state_d = ST_DONE;
                        found_d = 1'b0;
                        pw_d    = '0;
                        guess_d = '0;
                        sw_d    = '0;
                    end else if (state_q == ST_BASE) begin
                        h0_d    = hint;
                        idx_d   = '0;
                        sw_d    = N_SW'(1);
                        t_load  = 1'b1;
                        state_d = ST_PROBE;
                    end else if (state_q == ST_PROBE) begin
                        guess_d[idx_q] = h0_q > hint;
                        if ((h0_ext + 1'b1 != hint_ext) && (h0_ext - 1'b1 != hint_ext)) begin
                            err_d = 1'b1;
                        end
                        t_load = 1'b1;
                        if (idx_q == IW'(N_SW - 1)) begin
                            sw_d    = guess_d;
                            state_d = ST_SUBMIT;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            sw_d  = N_SW'(1) << idx_d;
                        end
                    end else begin
                        enter_d = 1'b1;
                        t_load  = 1'b1;
                        t_val   = TW'(RESULT_CYCLES);
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (!locked) begin
                    found_d = !err_q;
                    pw_d    = guess_q;
                    state_d = ST_DONE;
                end else if (t_exp) begin
                    found_d = 1'b0;
                    pw_d    = guess_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK50 or posedge rst_int) begin
        if (rst_int) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            guess_q <= '0;
            h0_q    <= '0;
            sw_q    <= '0;
            enter_q <= 1'b0;
            found_q <= 1'b0;
            pw_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            guess_q <= guess_d;
            h0_q    <= h0_d;
            sw_q    <= sw_d;
            enter_q <= enter_d;
            found_q <= found_d;
            pw_q    <= pw_d;
            err_q   <= err_d;
        end
    end

    assign sw_out = sw_q;
    assign enter  = enter_q;
    assign found  = found_q;
    assign pw_out = pw_q;
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done   = (state_q == ST_DONE);

endmodule
